// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and constants for the stopwatch BCD counter:
// control FSM states, BCD digit width and per-digit rollover limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DIG_MAX_DEC  = 4'd9;
  localparam logic [BCD_W-1:0] DIG_MAX_SEXT = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// One BCD digit that counts 0..MAX and rolls over to 0.
// carry_out is combinational so a chain of digits ripples within one cycle.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIG_MAX_DEC
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  assign carry_out = inc & (digit == MAX);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == MAX) ? '0 : digit + BCD_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch SS.cc counter: edge-detects div_clk_in, prescales edges into
// hundredth ticks and counts BCD digits under a start/stop/clear FSM.
// Optional lap snapshot display is enabled with STOPWATCH_LAP_EN.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_COUNT = 20,
  parameter int PRESCALE_W      = 8
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             div_clk_in,
  input  logic             start_stop,
  input  logic             clear,
  output logic             running,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] tenths,
  output logic [BCD_W-1:0] hundredths,
  output logic             overflow,
`ifdef STOPWATCH_LAP_EN
  input  logic             lap,
  output logic             lap_active,
`endif
  output state_e           state_dbg
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(TICKS_PER_COUNT - 1);

  state_e                state, state_next;
  logic                  div_q;
  logic                  div_edge;
  logic [PRESCALE_W-1:0] prescale;
  logic                  count_tick;
  logic                  c_hun, c_ten, c_ones, c_wrap;
  logic [BCD_W-1:0]      live_st, live_so, live_te, live_hu;

  assign div_edge  = div_clk_in & ~div_q;
  assign running   = (state == RUN);
  assign state_dbg = state;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (start_stop) begin
      unique case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // count_tick is registered, so digits move two cycles after the final edge.
  // Masking it with clear keeps a tick from leaking into the IDLE state.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= 1'b0;
      prescale   <= '0;
      count_tick <= 1'b0;
    end else begin
      div_q      <= div_clk_in;
      count_tick <= ~clear & (state == RUN) & div_edge & (prescale == PRESCALE_MAX);
      if (clear || state == IDLE) begin
        prescale <= '0;
      end else if (state == RUN && div_edge) begin
        prescale <= (prescale == PRESCALE_MAX) ? '0 : prescale + PRESCALE_W'(1);
      end
    end
  end

  bcd_digit #(.MAX(DIG_MAX_DEC)) u_hundredths (
    .clock_in(clock_in), .reset_n(reset_n), .inc(count_tick), .clr(clear),
    .digit(live_hu), .carry_out(c_hun)
  );
  bcd_digit #(.MAX(DIG_MAX_DEC)) u_tenths (
    .clock_in(clock_in), .reset_n(reset_n), .inc(c_hun), .clr(clear),
    .digit(live_te), .carry_out(c_ten)
  );
  bcd_digit #(.MAX(DIG_MAX_DEC)) u_sec_ones (
    .clock_in(clock_in), .reset_n(reset_n), .inc(c_ten), .clr(clear),
    .digit(live_so), .carry_out(c_ones)
  );
  bcd_digit #(.MAX(DIG_MAX_SEXT)) u_sec_tens (
    .clock_in(clock_in), .reset_n(reset_n), .inc(c_ones), .clr(clear),
    .digit(live_st), .carry_out(c_wrap)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)    overflow <= 1'b0;
    else if (clear)  overflow <= 1'b0;
    else if (c_wrap) overflow <= 1'b1;
  end

`ifdef STOPWATCH_LAP_EN
  logic                   lap_q;
  logic [4*BCD_W-1:0]     snap;

  // Lap only toggles in RUN; any exit from RUN drops back to the live view.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= 1'b0;
      snap  <= '0;
    end else if (clear || state_next != RUN) begin
      lap_q <= 1'b0;
    end else if (state == RUN && lap) begin
      lap_q <= ~lap_q;
      if (!lap_q) snap <= {live_st, live_so, live_te, live_hu};
    end
  end

  assign lap_active = lap_q;
  assign {sec_tens, sec_ones, tenths, hundredths} =
    lap_q ? snap : {live_st, live_so, live_te, live_hu};
`else
  assign {sec_tens, sec_ones, tenths, hundredths} = {live_st, live_so, live_te, live_hu};
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter (TICKS_PER_COUNT=2); digits are
// compared as a 16-bit BCD word so 12.34 reads as 16'h1234.
module tb_stopwatch_bcd_counter;
  import stopwatch_pkg::*;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic        div_clk_in;
  logic        start_stop;
  logic        clear;
  logic        running;
  logic [3:0]  sec_tens, sec_ones, tenths, hundredths;
  logic        overflow;
  state_e      state_dbg;
  logic [15:0] disp;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
  logic        lap_active;
`endif

  int checks = 0;
  int errors = 0;

  assign disp = {sec_tens, sec_ones, tenths, hundredths};

  // Clock / reset
  always #5 clock_in = ~clock_in;

  stopwatch_bcd_counter #(.TICKS_PER_COUNT(2), .PRESCALE_W(8)) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .div_clk_in (div_clk_in),
    .start_stop (start_stop),
    .clear      (clear),
    .running    (running),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .tenths     (tenths),
    .hundredths (hundredths),
    .overflow   (overflow),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
    .lap_active (lap_active),
`endif
    .state_dbg  (state_dbg)
  );

  // Driver tasks: inputs change on the falling edge only
  task automatic div_pulse();
    @(negedge clock_in) div_clk_in = 1'b1;
    @(negedge clock_in) div_clk_in = 1'b0;
  endtask

  task automatic count_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      div_pulse();
      div_pulse();
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clock_in);
  endtask

  task automatic pulse_ss();
    @(negedge clock_in) start_stop = 1'b1;
    @(negedge clock_in) start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clock_in) clear = 1'b1;
    @(negedge clock_in) clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock_in) reset_n = 1'b0;
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  // Scenarios
  task automatic test_reset();
    reset_n = 1'b0; div_clk_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    repeat (3) @(negedge clock_in);
    checks++;
    if (disp !== 16'h0000 || overflow !== 1'b0 || running !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: disp=%h ovf=%b run=%b st=%0d, want 0000 0 0 IDLE",
               disp, overflow, running, state_dbg);
    end
    reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  task automatic test_basic_count();
    pulse_ss();
    checks++;
    if (state_dbg !== RUN) begin
      errors++; $display("FAIL start_state: got %0d want RUN", state_dbg);
    end
    count_ticks(10);
    settle();
    checks++;
    if (disp !== 16'h0010 || running !== 1'b1) begin
      errors++; $display("FAIL basic_count: disp=%h run=%b want 0010 1", disp, running);
    end
  endtask

  task automatic test_carry_chain();
    count_ticks(989);
    settle();
    checks++;
    if (disp !== 16'h0999) begin
      errors++; $display("FAIL preload_0999: disp=%h want 0999", disp);
    end
    div_pulse();
    @(negedge clock_in) div_clk_in = 1'b1;
    @(negedge clock_in) div_clk_in = 1'b0;
    checks++;
    if (disp !== 16'h0999) begin
      errors++; $display("FAIL carry_early: disp=%h want 0999 one cycle after edge", disp);
    end
    @(negedge clock_in);
    checks++;
    if (disp !== 16'h1000) begin
      errors++; $display("FAIL carry_chain: disp=%h want 1000 two cycles after edge", disp);
    end
  endtask

  task automatic test_async_reset();
    count_ticks(234);
    settle();
    checks++;
    if (disp !== 16'h1234) begin
      errors++; $display("FAIL preload_1234: disp=%h want 1234", disp);
    end
    @(negedge clock_in);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (disp !== 16'h0000 || overflow !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: disp=%h ovf=%b run=%b want 0000 0 0", disp, overflow, running);
    end
    @(negedge clock_in) reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  task automatic test_wrap();
    pulse_ss();
    count_ticks(5999);
    settle();
    checks++;
    if (disp !== 16'h5999 || overflow !== 1'b0) begin
      errors++; $display("FAIL preload_5999: disp=%h ovf=%b want 5999 0", disp, overflow);
    end
    count_ticks(1);
    settle();
    checks++;
    if (disp !== 16'h0000 || overflow !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap: disp=%h ovf=%b run=%b want 0000 1 1", disp, overflow, running);
    end
    count_ticks(1);
    settle();
    checks++;
    if (disp !== 16'h0001 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: disp=%h ovf=%b want 0001 1", disp, overflow);
    end
  endtask

  task automatic test_pause_resume();
    div_pulse();
    pulse_ss();
    checks++;
    if (state_dbg !== PAUSE || running !== 1'b0) begin
      errors++; $display("FAIL pause_state: st=%0d run=%b want PAUSE 0", state_dbg, running);
    end
    for (int i = 0; i < 5; i++) div_pulse();
    settle();
    checks++;
    if (disp !== 16'h0001) begin
      errors++; $display("FAIL pause_hold: disp=%h want 0001", disp);
    end
    pulse_ss();
    div_pulse();
    settle();
    checks++;
    if (disp !== 16'h0002 || running !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL resume: disp=%h run=%b ovf=%b want 0002 1 1", disp, running, overflow);
    end
  endtask

  task automatic test_priority();
    @(negedge clock_in) begin clear = 1'b1; start_stop = 1'b1; end
    @(negedge clock_in) begin clear = 1'b0; start_stop = 1'b0; end
    checks++;
    if (state_dbg !== IDLE || disp !== 16'h0000 || overflow !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_over_ss: st=%0d disp=%h ovf=%b run=%b want IDLE 0000 0 0",
               state_dbg, disp, overflow, running);
    end
  endtask

  task automatic test_pause_with_tick();
    pulse_ss();
    div_pulse();
    @(negedge clock_in) begin div_clk_in = 1'b1; start_stop = 1'b1; end
    @(negedge clock_in) begin div_clk_in = 1'b0; start_stop = 1'b0; end
    settle();
    checks++;
    if (disp !== 16'h0001 || state_dbg !== PAUSE) begin
      errors++; $display("FAIL pause_and_tick: disp=%h st=%0d want 0001 PAUSE", disp, state_dbg);
    end
  endtask

  task automatic test_clear_with_tick();
    pulse_ss();
    count_ticks(2);
    settle();
    checks++;
    if (disp !== 16'h0003) begin
      errors++; $display("FAIL pre_clear_count: disp=%h want 0003", disp);
    end
    div_pulse();
    @(negedge clock_in) div_clk_in = 1'b1;
    @(negedge clock_in) begin div_clk_in = 1'b0; clear = 1'b1; end
    @(negedge clock_in) clear = 1'b0;
    settle();
    checks++;
    if (disp !== 16'h0000 || state_dbg !== IDLE) begin
      errors++; $display("FAIL clear_and_tick: disp=%h st=%0d want 0000 IDLE", disp, state_dbg);
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic pulse_lap();
    @(negedge clock_in) lap = 1'b1;
    @(negedge clock_in) lap = 1'b0;
  endtask

  task automatic test_lap();
    pulse_clear();
    pulse_ss();
    count_ticks(321);
    settle();
    pulse_lap();
    checks++;
    if (lap_active !== 1'b1 || disp !== 16'h0321) begin
      errors++; $display("FAIL lap_on: lap=%b disp=%h want 1 0321", lap_active, disp);
    end
    count_ticks(10);
    settle();
    checks++;
    if (disp !== 16'h0321) begin
      errors++; $display("FAIL lap_frozen: disp=%h want 0321", disp);
    end
    pulse_lap();
    checks++;
    if (lap_active !== 1'b0 || disp !== 16'h0331) begin
      errors++; $display("FAIL lap_release: lap=%b disp=%h want 0 0331", lap_active, disp);
    end
    pulse_lap();
    pulse_ss();
    checks++;
    if (lap_active !== 1'b0 || disp !== 16'h0331) begin
      errors++; $display("FAIL lap_exit_run: lap=%b disp=%h want 0 0331", lap_active, disp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_count();
    test_carry_chain();
    test_async_reset();
    test_wrap();
    test_pause_resume();
    test_priority();
    test_pause_with_tick();
    test_clear_with_tick();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
